// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle 32-bit SRL/SRA unit, one log stage per clock.
// Ports: clk, reset, start, dataA, dataB, Signal -> dataOut, busy, done.
module shift_right_seq #(
  parameter logic [5:0] SRL = 6'b000010,
  parameter logic [5:0] SRA = 6'b000011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  cnt;
  logic [31:0] acc;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [5:0]  sig_q;

  logic        accept;
  logic        is_srl;
  logic        is_sra;
  logic        fill;
  logic        oor;
  logic [31:0] stage;
  logic [31:0] result;

  assign accept = start && (state != SHIFT);
  assign is_srl = (sig_q == SRL);
  assign is_sra = (sig_q == SRA);
  assign fill   = is_sra & a_q[31];
  assign oor    = |b_q[31:5];
  assign busy   = (state == SHIFT);

  always_comb begin
    stage = acc;
    case (cnt)
      3'd0: if (b_q[4]) stage = {{16{fill}}, acc[31:16]};
      3'd1: if (b_q[3]) stage = {{8{fill}}, acc[31:8]};
      3'd2: if (b_q[2]) stage = {{4{fill}}, acc[31:4]};
      3'd3: if (b_q[1]) stage = {{2{fill}}, acc[31:2]};
      3'd4: if (b_q[0]) stage = {fill, acc[31:1]};
      default: stage = acc;
    endcase
  end

  // Unknown codes pass the operand through; range check
  // overrides the staged value for amounts above 31.
  always_comb begin
    result = stage;
    unique case (1'b1)
      !(is_srl || is_sra): result = a_q;
      oor:                 result = {32{fill}};
      default:             result = stage;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (cnt == 3'd4) state_n = DONE;
      DONE:    state_n = start ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 3'd0;
      acc     <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sig_q   <= 6'd0;
      dataOut <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        acc   <= dataA;
        a_q   <= dataA;
        b_q   <= dataB;
        sig_q <= Signal;
        cnt   <= 3'd0;
      end else if (state == SHIFT) begin
        acc <= stage;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd4) begin
          dataOut <= result;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed scoreboard bench for shift_right_seq.
// Drives SRL/SRA ops, checks latency, handshake and reset behaviour.
module tb_shift_right_seq;

  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic [5:0]  sig = 6'd0;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int          ntests = 0;
  int          nfail = 0;
  logic [31:0] sb[$];
  logic [31:0] last = 32'd0;
  longint      tdone = 0;
  longint      tprev = 0;

  always #5 clk = ~clk;

  shift_right_seq #(.SRL(SRL), .SRA(SRA)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (sig),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done)
  );

  function automatic logic [31:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [5:0]  s
  );
    logic f;
    if (s != SRL && s != SRA) return a;
    f = (s == SRA) && a[31];
    if (b[31:5] != 27'd0) return {32{f}};
    if (s == SRA) return $unsigned($signed(a) >>> b[4:0]);
    return a >> b[4:0];
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [5:0]  s,
    input bit          poke
  );
    int cyc;
    logic [31:0] exp;
    dataA = a;
    dataB = b;
    sig   = s;
    start = 1'b1;
    sb.push_back(model(a, b, s));
    step();
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    sig   = SRA;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    check({tag, "_done0"}, {31'd0, done}, 32'd0);
    cyc = 0;
    while (cyc < 20) begin
      step();
      cyc++;
      if (poke && cyc == 2) begin
        start = 1'b1;
        dataA = ~a;
        dataB = 32'd1;
        sig   = SRA;
      end
      if (poke && cyc == 3) start = 1'b0;
      if (busy && done) check({tag, "_excl"}, 32'd1, 32'd0);
      if (done) break;
      if (!busy) check({tag, "_busyN"}, 32'd0, 32'd1);
    end
    check({tag, "_lat"}, cyc, 32'd5);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    check({tag, "_data"}, dataOut, exp);
    last  = exp;
    tprev = tdone;
    tdone = $time;
  endtask

  task automatic idle_chk(input string tag);
    step();
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, dataOut, last);
  endtask

  initial begin
    step();
    step();
    check("rst_data", dataOut, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    run_op("srl4", 32'h80000000, 32'd4, SRL, 1'b0);
    check("srl4_abs", dataOut, 32'h08000000);
    idle_chk("srl4");
    run_op("sra4", 32'hF0000000, 32'd4, SRA, 1'b0);
    check("sra4_abs", dataOut, 32'hFF000000);
    idle_chk("sra4");
    run_op("srl4b", 32'hF0000000, 32'd4, SRL, 1'b0);
    check("srl4b_abs", dataOut, 32'h0F000000);
    idle_chk("srl4b");
    run_op("sra40", 32'h80000000, 32'd40, SRA, 1'b0);
    check("sra40_abs", dataOut, 32'hFFFFFFFF);
    run_op("srl32", 32'hFFFFFFFF, 32'd32, SRL, 1'b0);
    check("srl32_abs", dataOut, 32'h00000000);
    run_op("sra256", 32'h7FFFFFFF, 32'h100, SRA, 1'b0);
    check("sra256_abs", dataOut, 32'h00000000);
    idle_chk("oor");
    run_op("sh0", 32'hA5A5_1234, 32'd0, SRA, 1'b0);
    check("sh0_abs", dataOut, 32'hA5A51234);
    run_op("srl31", 32'hFFFFFFFF, 32'd31, SRL, 1'b0);
    check("srl31_abs", dataOut, 32'h00000001);
    run_op("sra31", 32'h80000000, 32'd31, SRA, 1'b0);
    check("sra31_abs", dataOut, 32'hFFFFFFFF);
    run_op("sra13", 32'h9ABC_DEF0, 32'd13, SRA, 1'b0);
    run_op("unk", 32'h12345678, 32'd4, 6'd0, 1'b0);
    check("unk_abs", dataOut, 32'h12345678);
    idle_chk("unk");

    run_op("poke", 32'h0000_F000, 32'd12, SRL, 1'b1);
    check("poke_abs", dataOut, 32'h0000000F);
    idle_chk("poke");

    run_op("b2b1", 32'hC000_0000, 32'd2, SRA, 1'b0);
    run_op("b2b2", 32'h0000_0100, 32'd8, SRL, 1'b0);
    check("b2b2_abs", dataOut, 32'h00000001);
    check("b2b_gap", 32'(tdone - tprev), 32'd60);
    idle_chk("b2b");

    dataA = 32'hDEAD_BEEF;
    dataB = 32'd3;
    sig   = SRL;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_data", dataOut, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    last  = 32'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) check("mid_nodone", 32'd1, 32'd0);
    end
    check("mid_idle", {31'd0, busy}, 32'd0);
    run_op("after", 32'h8000_0001, 32'd1, SRA, 1'b0);
    check("after_abs", dataOut, 32'hC0000000);
    idle_chk("after");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
